// File: rtl/ofdm_tx_frame_sched.sv
// OFDM TX frame scheduler: preamble from ROM, NSYM pass-through data symbols, optional zero guard gap.
// Define OFDM_TX_SCHED_GAP_EN to build the trailing GAP_LEN-sample zero gap.
module ofdm_tx_frame_sched #(
   parameter int PRE_LEN = 320,
   parameter int SYM_LEN = 80,
   parameter int NSYM_W  = 8,
   parameter int GAP_LEN = 16,
   parameter int ROM_AW  = 9
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic              START_I,
   input  logic [NSYM_W-1:0] NSYM_I,
   output logic [ROM_AW-1:0] PRE_ADR_O,
   input  logic [31:0]       PRE_DAT_I,
   input  logic [31:0]       DAT_I,
   input  logic              WE_I,
   input  logic              STB_I,
   input  logic              CYC_I,
   output logic              ACK_O,
   output logic [31:0]       DAT_O,
   output logic              WE_O,
   output logic              STB_O,
   output logic              CYC_O,
   input  logic              ACK_I,
   output logic              BUSY_O,
   output logic              DONE_O
);

   localparam int SAMP_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
   localparam logic [ROM_AW-1:0] PRE_LAST  = ROM_AW'(PRE_LEN - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [ROM_AW-1:0]  pre_cnt_q, pre_cnt_d;
   logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
   logic [NSYM_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic [NSYM_W-1:0]  nsym_q, nsym_d;
   logic               done_q, done_d;
   logic               xfer;
   logic               tail;

`ifdef OFDM_TX_SCHED_GAP_EN
   localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`else
   logic               unused_gap_len;
   assign unused_gap_len = (GAP_LEN != 0);
`endif

   always_comb begin
      ACK_O      = 1'b0;
      DAT_O      = '0;
      WE_O       = 1'b0;
      STB_O      = 1'b0;
      CYC_O      = 1'b0;
      PRE_ADR_O  = '0;
      xfer       = 1'b0;
      tail       = 1'b0;
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      samp_cnt_d = samp_cnt_q;
      sym_cnt_d  = sym_cnt_q;
      nsym_d     = nsym_q;
      done_d     = 1'b0;
`ifdef OFDM_TX_SCHED_GAP_EN
      gap_cnt_d  = gap_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (START_I) begin
               nsym_d    = NSYM_I;
               pre_cnt_d = '0;
               state_d   = S_PRE;
            end
         end

         S_PRE: begin
            CYC_O = 1'b1;
            STB_O = 1'b1;
            WE_O  = 1'b1;
            DAT_O = PRE_DAT_I;
            xfer  = ACK_I;
            // Look one address ahead on a transfer so the registered ROM lines up with pre_cnt.
            PRE_ADR_O = pre_cnt_q + ROM_AW'(xfer);
            if (xfer) begin
               if (pre_cnt_q == PRE_LAST) begin
                  pre_cnt_d = '0;
                  if (nsym_q == '0) begin
                     tail = 1'b1;
                  end else begin
                     samp_cnt_d = '0;
                     sym_cnt_d  = '0;
                     state_d    = S_DATA;
                  end
               end else begin
                  pre_cnt_d = pre_cnt_q + 1'b1;
               end
            end
         end

         S_DATA: begin
            CYC_O = 1'b1;
            STB_O = STB_I & CYC_I;
            WE_O  = WE_I;
            DAT_O = DAT_I;
            ACK_O = ACK_I;
            xfer  = WE_I & STB_I & CYC_I & ACK_I;
            if (xfer) begin
               if (samp_cnt_q == SAMP_LAST) begin
                  samp_cnt_d = '0;
                  if (sym_cnt_q == nsym_q - NSYM_W'(1)) begin
                     sym_cnt_d = '0;
                     tail      = 1'b1;
                  end else begin
                     sym_cnt_d = sym_cnt_q + 1'b1;
                  end
               end else begin
                  samp_cnt_d = samp_cnt_q + 1'b1;
               end
            end
         end

`ifdef OFDM_TX_SCHED_GAP_EN
         S_GAP: begin
            CYC_O = 1'b1;
            STB_O = 1'b1;
            WE_O  = 1'b1;
            xfer  = ACK_I;
            if (xfer) begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase

      // End of payload: either pad with the guard gap or close the frame immediately.
      if (tail) begin
`ifdef OFDM_TX_SCHED_GAP_EN
         gap_cnt_d = '0;
         state_d   = S_GAP;
`else
         done_d    = 1'b1;
         state_d   = S_IDLE;
`endif
      end
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state_q    <= S_IDLE;
         pre_cnt_q  <= '0;
         samp_cnt_q <= '0;
         sym_cnt_q  <= '0;
         nsym_q     <= '0;
         done_q     <= 1'b0;
`ifdef OFDM_TX_SCHED_GAP_EN
         gap_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         sym_cnt_q  <= sym_cnt_d;
         nsym_q     <= nsym_d;
         done_q     <= done_d;
`ifdef OFDM_TX_SCHED_GAP_EN
         gap_cnt_q  <= gap_cnt_d;
`endif
      end
   end

   assign BUSY_O = (state_q != S_IDLE);
   assign DONE_O = done_q;

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Scoreboard bench for ofdm_tx_frame_sched: driver queues the expected frame, monitor checks every output cycle.
module tb_ofdm_tx_frame_sched;

   localparam int PRE_LEN = 320;
   localparam int SYM_LEN = 80;
`ifdef OFDM_TX_SCHED_GAP_EN
   localparam int GAP_N = 16;
`else
   localparam int GAP_N = 0;
`endif
   localparam int LIMIT = 5000;

   logic        CLK_I = 1'b0;
   logic        RST_I, START_I, WE_I, STB_I, CYC_I, ACK_I;
   logic [7:0]  NSYM_I;
   logic [8:0]  PRE_ADR_O;
   logic [31:0] PRE_DAT_I, DAT_I, DAT_O;
   logic        ACK_O, WE_O, STB_O, CYC_O, BUSY_O, DONE_O;

   ofdm_tx_frame_sched dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .NSYM_I(NSYM_I),
      .PRE_ADR_O(PRE_ADR_O), .PRE_DAT_I(PRE_DAT_I),
      .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .ACK_O(ACK_O),
      .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I),
      .BUSY_O(BUSY_O), .DONE_O(DONE_O)
   );

   always #5 CLK_I = ~CLK_I;

   // Preamble ROM model and upstream source that advances on each upstream handshake.
   logic [31:0] rom [0:511];
   always @(posedge CLK_I) PRE_DAT_I <= rom[PRE_ADR_O];

   int unsigned up_idx = 0;
   always @(posedge CLK_I) if (WE_I && STB_I && CYC_I && ACK_O) up_idx <= up_idx + 1;
   assign DAT_I = up_idx;

   typedef struct { logic [31:0] dat; bit is_data; bit last; } exp_t;
   exp_t exp_q[$];

   int n_vec = 0, n_bad = 0;
   int mon_xfers = 0, dones = 0, frames_exp = 0;
   bit pend_done = 0;
   int ack_mode = 0, stb_mode = 0, ack_ph = 0;
   logic [3:0] ack_pat = 4'b1001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle out of reset, compare against the head of the expected stream.
   always @(negedge CLK_I) begin
      if (!RST_I) begin
         pend_done = 0;
      end else begin
         if (pend_done) begin
            chk("done_pulse", 32'(DONE_O), 32'd1);
            chk("done_cyc_low", 32'(CYC_O), 32'd0);
            pend_done = 0;
         end else begin
            chk("done_spurious", 32'(DONE_O), 32'd0);
         end
         if (DONE_O) dones++;
         if (exp_q.size() > 0) begin
            if (exp_q[0].is_data) begin
               chk("ack_pass", 32'(ACK_O), 32'(ACK_I));
               chk("stb_pass", 32'(STB_O), 32'(STB_I & CYC_I));
            end else begin
               chk("ack_low", 32'(ACK_O), 32'd0);
               if (CYC_O) chk("pre_gap_dat", DAT_O, exp_q[0].dat);
            end
            if (CYC_O && STB_O && WE_O && ACK_I) begin
               if (exp_q[0].is_data) chk("data_dat", DAT_O, exp_q[0].dat);
               if (exp_q[0].last) pend_done = 1;
               void'(exp_q.pop_front());
               mon_xfers++;
            end
         end else begin
            chk("idle_ack", 32'(ACK_O), 32'd0);
            if (CYC_O && STB_O && WE_O && ACK_I) chk("unexpected_xfer", 32'd1, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge CLK_I); #1;
      START_I = 1'b0;
      case (ack_mode)
         0: ACK_I = 1'b1;
         1: ACK_I = ($urandom_range(3) != 0);
         default: begin ACK_I = ack_pat[ack_ph]; ack_ph = (ack_ph + 1) % 4; end
      endcase
      STB_I = stb_mode ? ($urandom_range(3) != 0) : 1'b1;
   endtask

   task automatic do_reset(input int ncyc);
      exp_q.delete();
      RST_I = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         START_I = $urandom_range(1);
         NSYM_I  = $urandom;
         ACK_I   = $urandom_range(1);
         STB_I   = $urandom_range(1);
         @(posedge CLK_I); #1;
         chk("rst_cyc", 32'(CYC_O), 32'd0);
         chk("rst_stb", 32'(STB_O), 32'd0);
         chk("rst_we", 32'(WE_O), 32'd0);
         chk("rst_ack", 32'(ACK_O), 32'd0);
         chk("rst_busy", 32'(BUSY_O), 32'd0);
         chk("rst_done", 32'(DONE_O), 32'd0);
         chk("rst_dat", DAT_O, 32'd0);
         chk("rst_adr", 32'(PRE_ADR_O), 32'd0);
      end
      RST_I = 1'b1; START_I = 1'b0; ACK_I = 1'b1; STB_I = 1'b1;
   endtask

   // Issue one frame: expected stream = ROM[0..PRE_LEN-1], next n*SYM_LEN upstream words, GAP_N zeros.
   task automatic run_frame(input int n, input int am, input int sm, input int stall_at,
                            input int rst_at, input bit chk_len, input int extra);
      int total, k, start_x, stall_left;
      bit done_seen;
      total = PRE_LEN + n * SYM_LEN + GAP_N;
      for (int i = 0; i < total; i++) begin
         exp_t e;
         if (i < PRE_LEN) e = '{rom[i], 1'b0, 1'b0};
         else if (i < PRE_LEN + n * SYM_LEN) e = '{up_idx + 32'(i - PRE_LEN), 1'b1, 1'b0};
         else e = '{32'd0, 1'b0, 1'b0};
         e.last = (i == total - 1);
         exp_q.push_back(e);
      end
      frames_exp++;
      ack_mode = am; stb_mode = sm; ack_ph = 0;
      ACK_I = 1'b1; STB_I = 1'b1;
      start_x = mon_xfers; stall_left = 5;
      START_I = 1'b1; NSYM_I = 8'(n);
      k = 0; done_seen = 0;
      while (!done_seen && k < LIMIT) begin
         step();
         k++;
         if (k == 1) NSYM_I = $urandom;
         if (DONE_O) done_seen = 1;
         if (stall_at >= 0 && stall_left > 0 && (mon_xfers - start_x) >= stall_at) begin
            STB_I = 1'b0;
            START_I = (stall_left == 3);
            stall_left--;
         end
         if (rst_at >= 0 && (mon_xfers - start_x) == rst_at) begin
            frames_exp--;
            do_reset(1);
            return;
         end
      end
      if (!done_seen) begin
         n_vec++; n_bad++;
         $display("FAIL frame_timeout: no DONE_O after %0d cycles, needed one", k);
      end else if (chk_len) begin
         chk("frame_len", 32'(k - 1), 32'(total + extra));
      end
   endtask

   initial begin
      RST_I = 1'b0; START_I = 1'b0; NSYM_I = '0; WE_I = 1'b1; CYC_I = 1'b1;
      STB_I = 1'b1; ACK_I = 1'b0;
      for (int i = 0; i < 512; i++) rom[i] = $urandom;
      do_reset(3);
      run_frame(2, 0, 0, -1, -1, 1'b1, 0);                    // nominal two-symbol frame
      run_frame(1, 2, 0, -1, -1, 1'b0, 0);                    // ACK_I 1,0,0,1 stalls
      run_frame(0, 0, 0, -1, -1, 1'b1, 0);                    // no data symbols
      run_frame(2, 0, 0, PRE_LEN + 30, -1, 1'b1, 5);          // upstream stall + ignored START
      run_frame(2, 0, 0, -1, PRE_LEN + SYM_LEN + 40, 1'b0, 0); // reset mid-symbol
      run_frame(1, 0, 0, -1, -1, 1'b1, 0);                    // restart after reset
      for (int f = 0; f < 4; f++) run_frame($urandom_range(3), 1, 1, -1, -1, 1'b0, 0);
      repeat (3) step();
      chk("done_count", 32'(dones), 32'(frames_exp));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
